// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the bounded counter sequencer.
// State encoding is fixed so waveform viewers and neighbours agree on values.
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/cnt_ctrl_core.sv
// Loadable up/down counter with a terminal-value compare.
// Load beats enable; the controller never enables a step past the terminal.
import cnt_ctrl_pkg::*;

module cnt_core #(
    parameter int BW_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BW_CNT-1:0] load_val,
    input  logic              en,
    input  logic              dir,
    input  logic [BW_CNT-1:0] bound,
    output logic [BW_CNT-1:0] cnt,
    output logic              at_term
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (dir == DIR_DN) cnt <= cnt - 1'b1;
            else               cnt <= cnt + 1'b1;
        end
    end

    assign at_term = (dir == DIR_DN) ? (cnt == '0) : (cnt == bound);

endmodule

// File: rtl/cnt_ctrl.sv
// Sequencer for a bounded up/down counter: cfg handshake, run/pause/abort,
// terminal-count strobe and sticky one-shot completion flag.
import cnt_ctrl_pkg::*;

module cnt_ctrl #(
    parameter int BW_CNT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [BW_CNT-1:0] i_cfg_bound,
    input  logic              i_cfg_mode,
    input  logic              i_cfg_dir,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_abort,
    output logic [BW_CNT-1:0] o_cnt,
    output logic              o_tc,
    output logic              o_busy,
    output logic              o_done
);

    state_t            state;
    logic [BW_CNT-1:0] cfg_bound;
    logic              cfg_mode;
    logic              cfg_dir;
    logic              done;

    logic              idle_like;
    logic              accept;
    logic [BW_CNT-1:0] eff_bound;
    logic              eff_dir;
    logic [BW_CNT-1:0] start_val;
    logic              load;
    logic [BW_CNT-1:0] load_val;
    logic              en;
    logic              at_term;

    // Abort and reset outrank the handshake, so ready drops with them.
    always_comb begin
        idle_like   = (state == ST_IDLE) || (state == ST_DONE);
        o_cfg_ready = idle_like && !i_abort && !i_rst;
        accept      = i_cfg_valid && o_cfg_ready;
        eff_bound   = accept ? i_cfg_bound : cfg_bound;
        eff_dir     = accept ? i_cfg_dir : cfg_dir;
        start_val   = (eff_dir == DIR_DN) ? eff_bound : '0;
        o_tc        = (state == ST_RUN) && at_term && !i_pause;
    end

    always_comb begin
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        if (i_abort) begin
            load = 1'b1;
        end else if (idle_like) begin
            if (accept || i_start) begin
                load     = 1'b1;
                load_val = start_val;
            end
        end else if (o_tc) begin
            if (cfg_mode == MODE_RELOAD) begin
                load     = 1'b1;
                load_val = start_val;
            end
        end else if (state == ST_RUN && !i_pause) begin
            en = 1'b1;
        end
    end

    cnt_core #(
        .BW_CNT(BW_CNT)
    ) u_core (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .dir      (cfg_dir),
        .bound    (cfg_bound),
        .cnt      (o_cnt),
        .at_term  (at_term)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cfg_bound <= '1;
            cfg_mode  <= MODE_RELOAD;
            cfg_dir   <= DIR_UP;
            done      <= 1'b0;
        end else if (i_abort) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        cfg_bound <= i_cfg_bound;
                        cfg_mode  <= i_cfg_mode;
                        cfg_dir   <= i_cfg_dir;
                        done      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    if (i_start) begin
                        done  <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_pause) begin
                        state <= ST_PAUSE;
                    end else if (at_term && cfg_mode == MODE_ONESHOT) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (!i_pause) state <= ST_RUN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state == ST_RUN) || (state == ST_PAUSE);
    assign o_done = done;

endmodule
